// File: rtl/priority_code_capture.sv
// Capture stage behind a 4-to-2 priority encoder. It registers {A,B,v}, detects a new or changed
// valid code, and queues each event code in a show-ahead FIFO with drop accounting.
module priority_code_capture #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     A,
   input  logic                     B,
   input  logic                     v,
   output logic [1:0]               out_code,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   output logic [CNT_W-1:0]         drop_cnt,
   input  logic                     clear_drop
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [1:0]    in_code, prev_code;
   logic          in_v, prev_v;
   logic [1:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          evt, full, empty, pop, push, drop;

   // A code counts once per valid run, plus once more each time the code changes.
   assign evt   = in_v && (!prev_v || (in_code != prev_code));
   assign full  = (fifo_count == CW'(DEPTH));
   assign empty = (fifo_count == '0);
   assign pop   = !empty && out_ready;
   assign push  = evt && (!full || pop);
   assign drop  = evt && full && !pop;

   assign out_valid = !empty;
   assign out_code  = empty ? 2'b00 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         in_code    <= 2'b00;
         in_v       <= 1'b0;
         prev_code  <= 2'b00;
         prev_v     <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         in_code   <= {A, B};
         in_v      <= v;
         prev_code <= in_code;
         prev_v    <= in_v;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            fifo_count <= fifo_count + CW'(1);
         else if (pop && !push)
            fifo_count <= fifo_count - CW'(1);
         // Clear takes priority over a drop landing on the same edge.
         if (clear_drop) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
         end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr] <= in_code;
   end
endmodule
